// File: rtl/chan_slice_rr_arbiter.sv
// Round-robin N-to-1 arbiter over a sub-slice of a [LEFT:RIGHT] channel array,
// feeding one registered valid/ready output stage.
module chan_slice_rr_arbiter #(
  parameter int LEFT       = 0,
  parameter int RIGHT      = 3,
  parameter int WIDTH      = 8,
  parameter int SLICE_BASE = (LEFT < RIGHT) ? LEFT : RIGHT,
  parameter int SLICE_LEN  = ((LEFT > RIGHT) ? LEFT - RIGHT : RIGHT - LEFT) + 1,
  parameter int INDEX_W    = 8
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [LEFT:RIGHT]                in_valid,
  output logic [LEFT:RIGHT]                in_ready,
  input  logic [LEFT:RIGHT][WIDTH-1:0]     in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic [INDEX_W-1:0]               out_index
);

  localparam int LO    = (LEFT < RIGHT) ? LEFT : RIGHT;
  localparam int HI    = (LEFT < RIGHT) ? RIGHT : LEFT;
  localparam int S_LO  = SLICE_BASE;
  localparam int S_HI  = SLICE_BASE + SLICE_LEN - 1;
  localparam int OFF_W = (SLICE_LEN > 1) ? $clog2(SLICE_LEN) : 1;

  if (SLICE_LEN < 1 || S_LO < LO || S_HI > HI) begin : g_bad_slice
    $error("chan_slice_rr_arbiter: slice [%0d +: %0d] outside [%0d:%0d]", S_LO, SLICE_LEN, LO, HI);
  end
  if (INDEX_W < 63 && longint'(HI) >= (longint'(1) << INDEX_W)) begin : g_bad_index_w
    $error("chan_slice_rr_arbiter: INDEX_W=%0d too narrow for index %0d", INDEX_W, HI);
  end

  // Slice re-based to offset 0..SLICE_LEN-1 so the arbiter never sees declaration order.
  logic [SLICE_LEN-1:0]            req;
  logic [SLICE_LEN-1:0][WIDTH-1:0] slc_data;

  for (genvar g = 0; g < SLICE_LEN; g++) begin : g_slc
    assign req[g]      = in_valid[S_LO + g];
    assign slc_data[g] = in_data[S_LO + g];
  end

  logic [OFF_W-1:0] last_off;
  logic [OFF_W-1:0] grant_off;
  logic [OFF_W-1:0] cand;
  logic             grant_vld;
  logic             load;

  assign load = !out_valid || out_ready;

  // Scan from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_off = last_off;
    cand      = '0;
    for (int k = SLICE_LEN; k >= 1; k--) begin
      cand = OFF_W'((int'(last_off) + k) % SLICE_LEN);
      if (req[cand]) begin
        grant_vld = 1'b1;
        grant_off = cand;
      end
    end
  end

  for (genvar c = LO; c <= HI; c++) begin : g_rdy
    if (c >= S_LO && c <= S_HI) begin : g_in
      assign in_ready[c] = load && grant_vld && (grant_off == OFF_W'(c - S_LO));
    end else begin : g_out
      assign in_ready[c] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= INDEX_W'(S_LO);
      last_off  <= OFF_W'(SLICE_LEN - 1);
    end else if (load) begin
      out_valid <= grant_vld;
      if (grant_vld) begin
        out_data  <= slc_data[grant_off];
        out_index <= INDEX_W'(S_LO) + INDEX_W'(grant_off);
        last_off  <= grant_off;
      end
    end
  end

  // Out-of-slice requests and payloads are intentionally ignored.
  logic unused_ok;
  assign unused_ok = &{1'b0, in_valid, in_data};

endmodule

// File: tb/tb_chan_slice_rr_arbiter.sv
// Scoreboard bench: three arbiter configurations (ascending, descending, sub-slice)
// driven with directed vectors; monitors pop expected words on each output handshake.
module tb_chan_slice_rr_arbiter;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int idx;
    int data;
  } exp_t;

  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;
  int checks = 0;
  int errors = 0;

  // A: ascending [0:3], full slice
  logic [0:3]       a_vld, a_rdy;
  logic [0:3][7:0]  a_dat;
  logic             a_ov, a_or;
  logic [7:0]       a_od, a_oi;
  // B: descending [3:0], full slice
  logic [3:0]       b_vld, b_rdy;
  logic [3:0][7:0]  b_dat;
  logic             b_ov, b_or;
  logic [7:0]       b_od, b_oi;
  // C: [0:7], slice 2..4
  logic [0:7]       c_vld, c_rdy;
  logic [0:7][7:0]  c_dat;
  logic             c_ov, c_or;
  logic [7:0]       c_od, c_oi;

  chan_slice_rr_arbiter #(.LEFT(0), .RIGHT(3), .WIDTH(8)) u_a (
    .clock(clock), .reset_n(reset_n), .in_valid(a_vld), .in_ready(a_rdy), .in_data(a_dat),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_index(a_oi));

  chan_slice_rr_arbiter #(.LEFT(3), .RIGHT(0), .WIDTH(8)) u_b (
    .clock(clock), .reset_n(reset_n), .in_valid(b_vld), .in_ready(b_rdy), .in_data(b_dat),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_index(b_oi));

  chan_slice_rr_arbiter #(.LEFT(0), .RIGHT(7), .WIDTH(8), .SLICE_BASE(2), .SLICE_LEN(3)) u_c (
    .clock(clock), .reset_n(reset_n), .in_valid(c_vld), .in_ready(c_rdy), .in_data(c_dat),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .out_index(c_oi));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_a(input int i, input int d); qa.push_back('{i, d}); endtask
  task automatic push_b(input int i, input int d); qb.push_back('{i, d}); endtask
  task automatic push_c(input int i, input int d); qc.push_back('{i, d}); endtask

  always @(negedge clock) begin
    if (reset_n && a_ov && a_or) begin
      if (qa.size() == 0) chk("a_unexpected_word", qa.size(), 1);
      else begin
        ea = qa.pop_front();
        chk("a_index", a_oi, ea.idx);
        chk("a_data", a_od, ea.data);
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && b_ov && b_or) begin
      if (qb.size() == 0) chk("b_unexpected_word", qb.size(), 1);
      else begin
        eb = qb.pop_front();
        chk("b_index", b_oi, eb.idx);
        chk("b_data", b_od, eb.data);
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && c_ov && c_or) begin
      if (qc.size() == 0) chk("c_unexpected_word", qc.size(), 1);
      else begin
        ec = qc.pop_front();
        chk("c_index", c_oi, ec.idx);
        chk("c_data", c_od, ec.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    a_vld = '0; b_vld = '0; c_vld = '0;
    a_or = 1'b1; b_or = 1'b1; c_or = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_dat[i] = 8'(16 + i);
      b_dat[i] = 8'(32 + i);
    end
    b_dat[2] = 8'hA5;
    for (int i = 0; i < 8; i++) c_dat[i] = 8'(48 + i);

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("a_rst_valid", a_ov, 0);
    chk("a_rst_data", a_od, 0);
    chk("a_rst_index", a_oi, 0);
    chk("b_rst_index", b_oi, 0);
    chk("c_rst_valid", c_ov, 0);
    chk("c_rst_index", c_oi, 2);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // A: all requesting, full throughput rotation
    a_vld = '1;
    for (int k = 0; k < 8; k++) push_a(k % 4, 16 + k % 4);
    repeat (8) @(posedge clock);
    #1 a_vld = '0;
    repeat (2) @(posedge clock);
    #1 chk("a_rr_all_served", qa.size(), 0);

    // B: descending declaration, same order
    b_vld = '1;
    push_b(0, 32); push_b(1, 33); push_b(2, 8'hA5); push_b(3, 35);
    repeat (4) @(posedge clock);
    #1 b_vld = '0;
    repeat (2) @(posedge clock);
    #1 chk("b_rr_all_served", qb.size(), 0);

    // C: sub-slice 2..4 only
    c_vld = '1;
    for (int k = 0; k < 6; k++) push_c(2 + k % 3, 48 + 2 + k % 3);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("c_outside_ready", {c_rdy[0], c_rdy[1], c_rdy[5], c_rdy[6], c_rdy[7]}, 0);
      chk("c_winner_ready", c_rdy[2 + k % 3], 1);
      @(posedge clock);
    end
    #1 c_vld = '0;
    repeat (2) @(posedge clock);
    #1 chk("c_rr_all_served", qc.size(), 0);

    // A: backpressure with a word held in the output register
    a_or = 1'b0;
    a_vld = '1;
    push_a(0, 16);
    @(posedge clock);
    repeat (5) begin
      #2;
      chk("a_stall_valid", a_ov, 1);
      chk("a_stall_index", a_oi, 0);
      chk("a_stall_data", a_od, 16);
      chk("a_stall_ready", a_rdy, 0);
      @(posedge clock);
    end
    #1 a_or = 1'b1;
    push_a(1, 17); push_a(2, 18);
    #1 chk("a_release_ready1", a_rdy[1], 1);
    repeat (2) @(posedge clock);
    #1 a_vld = '0;
    repeat (2) @(posedge clock);
    #1 chk("a_stall_all_served", qa.size(), 0);

    // A: sparse requests, last=2 -> 1, then {1,3} -> 3, 1
    a_vld = '0; a_vld[1] = 1'b1;
    push_a(1, 17);
    @(posedge clock);
    #1 a_vld[3] = 1'b1;
    push_a(3, 19); push_a(1, 17);
    repeat (2) @(posedge clock);
    #1 a_vld = '0;
    repeat (2) @(posedge clock);
    #1 chk("a_sparse_all_served", qa.size(), 0);

    // A: asynchronous reset mid-stream; the in-flight word (index 3) is dropped
    a_vld = '1;
    push_a(2, 18);
    @(posedge clock);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1 chk("a_async_reset_valid", a_ov, 0);
    chk("a_async_reset_index", a_oi, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    push_a(0, 16); push_a(1, 17);
    repeat (2) @(posedge clock);
    #1 a_vld = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("a_post_reset_served", qa.size(), 0);
    chk("b_final_empty", qb.size(), 0);
    chk("c_final_empty", qc.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
